ctrl_pipe_unit: RTL and testbench
=================================

# ctrl_pipe_unit

Pipelined control unit for the five-stage RISC-V core. It decodes the instruction held in ID into a control bundle and carries that bundle through the EX, MEM and WB pipeline registers. It also detects load-use hazards, inserts bubbles on branch/jump redirect, and holds EX for a parametrised number of cycles for M-extension multiply/divide. It sits between the IF/ID register and the datapath stage muxes, and supersedes the purely combinational opcode decoder.

## Interface
- `REG_AW`, 5: register-index width.
- `M_EN`, 1: 1 = accept M-extension ops (R-type, funct7=0000001); 0 = flag them illegal.
- `MD_LAT`, 4: EX occupancy in cycles for an M op. Legal range is at least 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `id_valid` in 1: the IF/ID register holds a real instruction.
- `id_instr` in 32: instruction in ID. Fields used: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
- `ex_redirect` in 1: EX resolved a taken branch or a JAL/JALR; the PC is being redirected.
- `stall_id` out 1: hold the PC and the IF/ID register this cycle (combinational).
- `ex_valid`, `mem_valid`, `wb_valid` out 1 each: the stage holds a real instruction.
- `ex_ctrl` out CTRL_W: full bundle {RegWrite, ResultSrc[1:0], MemRead, MemWrite, ALUOp[1:0], ALUSrc, ALUASrc, Branch, Jump[1:0], MulDiv}.
- `ex_funct3` out 3: funct3 of the instruction in EX.
- `ex_illegal` out 1: the instruction in EX has an unsupported encoding.
- `mem_ctrl` out 5: {RegWrite, ResultSrc[1:0], MemRead, MemWrite}.
- `wb_ctrl` out 3: {RegWrite, ResultSrc[1:0]}.
- `ex_rd`, `mem_rd`, `wb_rd` out REG_AW each: destination register per stage.
- `md_busy` out 1: an M op in EX has remaining cycles.

## Operation
- **Decode table:**
  - R-type: RegWrite, ALUOp=10.
  - I-ALU: RegWrite, ALUSrc, ALUOp=10.
  - Load: RegWrite, ResultSrc=01, MemRead, ALUSrc.
  - Store: MemWrite, ALUSrc.
  - Branch: Branch, ALUOp=01.
  - JAL: RegWrite, ResultSrc=11, Jump=01.
  - JALR: RegWrite, ResultSrc=11, ALUSrc, Jump=10.
  - LUI: RegWrite, ResultSrc=10, ALUSrc.
  - AUIPC: RegWrite, ALUSrc, ALUASrc.
  - M op: R-type bundle plus MulDiv=1.
- **Illegal encodings:** any other opcode, or an M op when M_EN=0, decodes to an all-zero bundle with illegal=1. The instruction still counts as valid.
- **Register use:** rs1 is used by every opcode except LUI, AUIPC and JAL. rs2 is used by R-type, Store and Branch.
- **Load-use stall:** stall_id=1 when ex_valid, ex_ctrl.MemRead, ex_rd≠0, and a used ID source equals ex_rd. EX is loaded with a bubble on the next edge.
- **Redirect:** ex_redirect=1 loads a bubble into EX on the next edge, discarding the ID instruction. It forces stall_id=0 and overrides the load-use stall.
- **M op:**
  - On entering EX, the counter loads MD_LAT−1.
  - While the counter is non-zero: md_busy=1, stall_id=1, EX holds its contents, MEM receives a bubble, and the counter decrements.
  - When MD_LAT=1 there is no stall.
- **ex_redirect during md_busy:** cannot legally occur. The block ignores it and a bench assertion flags it.
- **Stage advance:** MEM←EX and WB←MEM every cycle unless EX is held.
- **Bubbles:** a bubble means valid=0, all control bits 0, rd=0. Downstream logic must never see a write enable without valid.

## Timing
- **Reset:** every valid, ctrl, rd, funct3, illegal and counter bit is 0. stall_id=0 and md_busy=0 are asserted immediately, asynchronously.
- **Latency:** one cycle from ID to EX, then EX→MEM→WB one cycle each.
- **Load-use:** costs exactly one stall cycle.
- **M op:** costs MD_LAT−1 stall cycles.
- **Output timing:**
  - stall_id is a same-cycle combinational function of the ID inputs and the EX registers.
  - All other outputs come directly from registers.
- **Reset mid-M-op:** the counter clears and the held instruction is dropped.
- **id_valid=0:** decode yields a bubble, with no hazard check.

## Structure
- Package `ctrl_pkg` holds:
  - opcode localparams;
  - the ResultSrc, ALUOp and Jump encodings;
  - the bundle typedef `ctrl_t`;
  - CTRL_W;
  - the field-slice functions for the mem and wb subsets.
- Combinational sub-module `ctrl_decode` maps {opcode, funct7, M_EN} to `ctrl_t`, illegal, use_rs1 and use_rs2.
- The hazard logic, counter and stage registers live in the top level.

## Test plan
- **Reset mid M op:** MD_LAT=4; drop rst_n at the 2nd busy cycle → all outputs 0 immediately. After release, the first new instruction reaches EX one cycle later.
- **Load-use stall:** `lw x5,0(x1)` then `add x6,x5,x2` → stall_id=1 for one cycle, EX bubble, add in EX the following cycle. ex_rd goes 5, 0, 6.
- **Load to x0:** `lw x0` then `add x6,x0,x2` → no stall. Also `lw x5` then `lui x5,1` → no stall, since LUI uses no rs.
- **M op stalls:** M_EN=1, MD_LAT=4, `mul x3,x1,x2` → md_busy and stall_id high for 3 cycles, then 3 MEM bubbles. mem_rd=3 appears after the 3rd bubble.
- **Redirect beats stall:** ex_redirect coincident with a load-use condition → stall_id=0, EX bubble next cycle.
- **Illegal encodings:** opcode 0x7F → ex_valid=1, ex_illegal=1, ex_ctrl=0. With M_EN=0, `mul` → ex_illegal=1 and no stall.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings, control bundle type and stage-subset helpers for the
// pipelined control unit.
package ctrl_pkg;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [6:0] F7MulDiv = 7'b0000001;

  localparam logic [1:0] ResAlu = 2'b00;
  localparam logic [1:0] ResMem = 2'b01;
  localparam logic [1:0] ResImm = 2'b10;
  localparam logic [1:0] ResPc4 = 2'b11;

  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluSub = 2'b01;
  localparam logic [1:0] AluFn  = 2'b10;

  localparam logic [1:0] JmpNone = 2'b00;
  localparam logic [1:0] JmpJal  = 2'b01;
  localparam logic [1:0] JmpJalr = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       alu_a_src;
    logic       branch;
    logic [1:0] jump;
    logic       mul_div;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  function automatic logic [4:0] mem_slice(input ctrl_t c);
    return {c.reg_write, c.result_src, c.mem_read, c.mem_write};
  endfunction

  function automatic logic [2:0] wb_slice(input logic [4:0] m);
    return m[4:2];
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control bundle, illegal flag and which source
// registers the instruction actually reads.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit M_EN = 1'b1
) (
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  output ctrl_t      ctrl,
  output logic       illegal,
  output logic       use_rs1,
  output logic       use_rs2
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OpR: begin
        if (funct7 == F7MulDiv && !M_EN) begin
          illegal = 1'b1;
        end else begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = AluFn;
          ctrl.mul_div   = (funct7 == F7MulDiv);
          use_rs1        = 1'b1;
          use_rs2        = 1'b1;
        end
      end
      OpImm: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = AluFn;
        use_rs1        = 1'b1;
      end
      OpLoad: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = ResMem;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_src    = 1'b1;
        use_rs1         = 1'b1;
      end
      OpStore: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
      end
      OpBranch: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = AluSub;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
      end
      OpJal: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = ResPc4;
        ctrl.jump       = JmpJal;
      end
      OpJalr: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = ResPc4;
        ctrl.alu_src    = 1'b1;
        ctrl.jump       = JmpJalr;
        use_rs1         = 1'b1;
      end
      OpLui: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = ResImm;
        ctrl.alu_src    = 1'b1;
      end
      OpAuipc: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_a_src = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: decodes ID, carries control through EX/MEM/WB and
// handles load-use stalls, redirect bubbles and multi-cycle M ops.
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter bit          M_EN   = 1'b1,
  parameter int unsigned MD_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic              ex_redirect,
  output logic              stall_id,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [2:0]        ex_funct3,
  output logic              ex_illegal,
  output logic [4:0]        mem_ctrl,
  output logic [2:0]        wb_ctrl,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] mem_rd,
  output logic [REG_AW-1:0] wb_rd,
  output logic              md_busy
);

  localparam int unsigned CntW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam logic [CntW-1:0] MdLoad = CntW'(MD_LAT - 1);

  ctrl_t id_ctrl;
  logic  id_illegal, use_rs1, use_rs2, load_use;

  logic [REG_AW-1:0] id_rd, id_rs1, id_rs2;
  assign id_rd  = id_instr[7 +: REG_AW];
  assign id_rs1 = id_instr[15 +: REG_AW];
  assign id_rs2 = id_instr[20 +: REG_AW];

  ctrl_decode #(.M_EN(M_EN)) u_decode (
    .opcode (id_instr[6:0]),
    .funct7 (id_instr[31:25]),
    .ctrl   (id_ctrl),
    .illegal(id_illegal),
    .use_rs1(use_rs1),
    .use_rs2(use_rs2)
  );

  logic              ex_valid_q, ex_valid_d, mem_valid_q, mem_valid_d, wb_valid_q;
  ctrl_t             ex_ctrl_q, ex_ctrl_d;
  logic [2:0]        ex_funct3_q, ex_funct3_d;
  logic              ex_illegal_q, ex_illegal_d;
  logic [4:0]        mem_ctrl_q, mem_ctrl_d;
  logic [2:0]        wb_ctrl_q;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q;
  logic [CntW-1:0]   md_cnt_q, md_cnt_d;

  assign md_busy  = (md_cnt_q != '0);
  assign load_use = id_valid && ex_valid_q && ex_ctrl_q.mem_read && (ex_rd_q != '0) &&
                    ((use_rs1 && id_rs1 == ex_rd_q) || (use_rs2 && id_rs2 == ex_rd_q));
  // Redirect is ignored while an M op holds EX, so it only suppresses load-use.
  assign stall_id = md_busy || (load_use && !ex_redirect);

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_ctrl_d    = ex_ctrl_q;
    ex_funct3_d  = ex_funct3_q;
    ex_illegal_d = ex_illegal_q;
    ex_rd_d      = ex_rd_q;
    md_cnt_d     = md_cnt_q;
    if (md_busy) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end else if (ex_redirect || load_use || !id_valid) begin
      ex_valid_d   = 1'b0;
      ex_ctrl_d    = '0;
      ex_funct3_d  = '0;
      ex_illegal_d = 1'b0;
      ex_rd_d      = '0;
      md_cnt_d     = '0;
    end else begin
      ex_valid_d   = 1'b1;
      ex_ctrl_d    = id_ctrl;
      ex_funct3_d  = id_instr[14:12];
      ex_illegal_d = id_illegal;
      ex_rd_d      = id_rd;
      md_cnt_d     = id_ctrl.mul_div ? MdLoad : '0;
    end

    if (md_busy) begin
      mem_valid_d = 1'b0;
      mem_ctrl_d  = '0;
      mem_rd_d    = '0;
    end else begin
      mem_valid_d = ex_valid_q;
      mem_ctrl_d  = mem_slice(ex_ctrl_q);
      mem_rd_d    = ex_rd_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= '0;
      ex_funct3_q  <= '0;
      ex_illegal_q <= 1'b0;
      ex_rd_q      <= '0;
      md_cnt_q     <= '0;
      mem_valid_q  <= 1'b0;
      mem_ctrl_q   <= '0;
      mem_rd_q     <= '0;
      wb_valid_q   <= 1'b0;
      wb_ctrl_q    <= '0;
      wb_rd_q      <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_funct3_q  <= ex_funct3_d;
      ex_illegal_q <= ex_illegal_d;
      ex_rd_q      <= ex_rd_d;
      md_cnt_q     <= md_cnt_d;
      mem_valid_q  <= mem_valid_d;
      mem_ctrl_q   <= mem_ctrl_d;
      mem_rd_q     <= mem_rd_d;
      wb_valid_q   <= mem_valid_q;
      wb_ctrl_q    <= wb_slice(mem_ctrl_q);
      wb_rd_q      <= mem_rd_q;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_ctrl    = ex_ctrl_q;
  assign ex_funct3  = ex_funct3_q;
  assign ex_illegal = ex_illegal_q;
  assign ex_rd      = ex_rd_q;
  assign mem_valid  = mem_valid_q;
  assign mem_ctrl   = mem_ctrl_q;
  assign mem_rd     = mem_rd_q;
  assign wb_valid   = wb_valid_q;
  assign wb_ctrl    = wb_ctrl_q;
  assign wb_rd      = wb_rd_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit: hand-computed control bundles and stage
// timing, plus an M_EN=0 instance sharing the same stimulus.
module tb_ctrl_pipe_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_instr = '0;
  logic        ex_redirect = 1'b0;

  logic        stall_id, ex_valid, mem_valid, wb_valid, ex_illegal, md_busy;
  logic [12:0] ex_ctrl;
  logic [2:0]  ex_funct3, wb_ctrl;
  logic [4:0]  mem_ctrl, ex_rd, mem_rd, wb_rd;

  logic        n_stall_id, n_ex_valid, n_mem_valid, n_wb_valid, n_ex_illegal, n_md_busy;
  logic [12:0] n_ex_ctrl;
  logic [2:0]  n_ex_funct3, n_wb_ctrl;
  logic [4:0]  n_mem_ctrl, n_ex_rd, n_mem_rd, n_wb_rd;

  int errors = 0;
  int checks = 0;

  // Expected bundles {rw, rs[1:0], mr, mw, aluop[1:0], asrc, aasrc, br, jmp[1:0], md}
  localparam logic [12:0] CtlLoad  = 13'b1_01_1_0_00_1_0_0_00_0;
  localparam logic [12:0] CtlR     = 13'b1_00_0_0_10_0_0_0_00_0;
  localparam logic [12:0] CtlMul   = 13'b1_00_0_0_10_0_0_0_00_1;
  localparam logic [12:0] CtlLui   = 13'b1_10_0_0_00_1_0_0_00_0;
  localparam logic [12:0] CtlStore = 13'b0_00_0_1_00_1_0_0_00_0;

  ctrl_pipe_unit #(.REG_AW(5), .M_EN(1'b1), .MD_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .ex_redirect(ex_redirect), .stall_id(stall_id), .ex_valid(ex_valid),
    .mem_valid(mem_valid), .wb_valid(wb_valid), .ex_ctrl(ex_ctrl), .ex_funct3(ex_funct3),
    .ex_illegal(ex_illegal), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl), .ex_rd(ex_rd),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .md_busy(md_busy)
  );

  ctrl_pipe_unit #(.REG_AW(5), .M_EN(1'b0), .MD_LAT(4)) dut_nom (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .ex_redirect(ex_redirect), .stall_id(n_stall_id), .ex_valid(n_ex_valid),
    .mem_valid(n_mem_valid), .wb_valid(n_wb_valid), .ex_ctrl(n_ex_ctrl),
    .ex_funct3(n_ex_funct3), .ex_illegal(n_ex_illegal), .mem_ctrl(n_mem_ctrl),
    .wb_ctrl(n_wb_ctrl), .ex_rd(n_ex_rd), .mem_rd(n_mem_rd), .wb_rd(n_wb_rd),
    .md_busy(n_md_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Redirect must never coincide with an M op holding EX.
  always @(negedge clk) begin
    if (rst_n && md_busy && ex_redirect) begin
      errors++;
      $error("FAIL redirect_during_md_busy: observed=1 expected=0");
    end
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins);
    id_valid = 1'b1;
    id_instr = ins;
  endtask

  logic [31:0] lw_x5, lw_x0, add_x6_x5, add_x6_x0, lui_x5, sw_x5, mul_x3;

  initial begin
    lw_x5     = enc_r(7'd0, 5'd0, 5'd1, 3'b010, 5'd5, 7'b0000011);
    lw_x0     = enc_r(7'd0, 5'd0, 5'd1, 3'b010, 5'd0, 7'b0000011);
    add_x6_x5 = enc_r(7'd0, 5'd2, 5'd5, 3'b000, 5'd6, 7'b0110011);
    add_x6_x0 = enc_r(7'd0, 5'd2, 5'd0, 3'b000, 5'd6, 7'b0110011);
    lui_x5    = {20'd1, 5'd5, 7'b0110111};
    sw_x5     = enc_r(7'd0, 5'd5, 5'd1, 3'b010, 5'd0, 7'b0100011);
    mul_x3    = enc_r(7'd1, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011);

    // Reset state
    #2;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_ctrl", ex_ctrl, 0);
    check("rst_stall", stall_id, 0);
    check("rst_md_busy", md_busy, 0);
    check("rst_wb_rd", wb_rd, 0);
    step();
    rst_n = 1'b1;

    // Load-use: lw x5 then add x6,x5,x2
    issue(lw_x5);
    step();
    check("lu_ex_rd_lw", ex_rd, 5);
    check("lu_ex_ctrl_lw", ex_ctrl, CtlLoad);
    check("lu_ex_funct3", ex_funct3, 3'b010);
    issue(add_x6_x5);
    #1 check("lu_stall", stall_id, 1);
    step();
    check("lu_ex_rd_bubble", ex_rd, 0);
    check("lu_ex_valid_bubble", ex_valid, 0);
    check("lu_mem_ctrl_lw", mem_ctrl, 5'b1_01_1_0);
    check("lu_stall_release", stall_id, 0);
    step();
    check("lu_ex_rd_add", ex_rd, 6);
    check("lu_ex_ctrl_add", ex_ctrl, CtlR);
    check("lu_wb_rd", wb_rd, 5);
    check("lu_wb_ctrl", wb_ctrl, 3'b1_01);
    check("lu_mem_valid_bubble", mem_valid, 0);

    // Load to x0 never stalls
    issue(lw_x0);
    step();
    issue(add_x6_x0);
    #1 check("x0_no_stall", stall_id, 0);
    step();
    check("x0_ex_rd", ex_rd, 6);

    // LUI reads no source register
    issue(lw_x5);
    step();
    issue(lui_x5);
    #1 check("lui_no_stall", stall_id, 0);
    step();
    check("lui_ex_rd", ex_rd, 5);
    check("lui_ex_ctrl", ex_ctrl, CtlLui);

    // Store data source rs2 triggers load-use
    issue(lw_x5);
    step();
    issue(sw_x5);
    #1 check("sw_stall", stall_id, 1);
    step();
    check("sw_bubble", ex_valid, 0);
    step();
    check("sw_ex_ctrl", ex_ctrl, CtlStore);

    // Redirect beats load-use
    issue(lw_x5);
    step();
    issue(add_x6_x5);
    ex_redirect = 1'b1;
    #1 check("redir_no_stall", stall_id, 0);
    step();
    ex_redirect = 1'b0;
    check("redir_ex_valid", ex_valid, 0);
    check("redir_ex_rd", ex_rd, 0);
    check("redir_mem_rd", mem_rd, 5);

    // M op: MD_LAT=4 gives three busy/stall cycles and three MEM bubbles
    issue(mul_x3);
    step();
    id_valid = 1'b0;
    check("mul_ex_ctrl", ex_ctrl, CtlMul);
    check("mul_ex_rd", ex_rd, 3);
    check("mul_busy0", md_busy, 1);
    check("mul_stall0", stall_id, 1);
    check("nom_mul_illegal", n_ex_illegal, 1);
    check("nom_mul_ctrl", n_ex_ctrl, 0);
    check("nom_mul_valid", n_ex_valid, 1);
    check("nom_mul_busy", n_md_busy, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("mul_mem_bubble%0d", i), mem_valid, 0);
      check($sformatf("mul_busy%0d", i + 1), md_busy, (i < 2) ? 1 : 0);
      check($sformatf("mul_stall%0d", i + 1), stall_id, (i < 2) ? 1 : 0);
    end
    step();
    check("mul_mem_rd", mem_rd, 3);
    check("mul_mem_valid", mem_valid, 1);
    check("mul_mem_ctrl", mem_ctrl, 5'b1_00_0_0);

    // Illegal opcode still counts as valid
    issue(32'h0000007F);
    step();
    id_valid = 1'b0;
    check("ill_ex_valid", ex_valid, 1);
    check("ill_ex_illegal", ex_illegal, 1);
    check("ill_ex_ctrl", ex_ctrl, 0);

    // Reset at the second busy cycle of an M op
    issue(mul_x3);
    step();
    id_valid = 1'b0;
    step();
    check("rmid_busy_before", md_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rmid_busy", md_busy, 0);
    check("rmid_stall", stall_id, 0);
    check("rmid_ex_valid", ex_valid, 0);
    check("rmid_ex_rd", ex_rd, 0);
    check("rmid_ex_ctrl", ex_ctrl, 0);
    step();
    rst_n = 1'b1;
    issue(add_x6_x5);
    step();
    id_valid = 1'b0;
    check("rmid_new_ex_rd", ex_rd, 6);
    check("rmid_new_ex_valid", ex_valid, 1);
    check("rmid_new_busy", md_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
